// File: rtl/spi_pkg.sv
// Shared types for the SCL/SDA link target: FSM state encoding and counter sizing.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } spi_tgt_state_t;

    // A zero-bit response phase still needs a 1-bit counter so the RTL stays legal.
    function automatic int ctr_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, plus a third register for edge detection.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_rise  = r_s2 & ~r_s3;
    assign o_fall  = ~r_s2 & r_s3;

endmodule

// File: rtl/spi_target.sv
// Responder end of the SCL/SDA link: shifts in a WRITE_WIDTH word on SCL rises,
// optionally returns READ_WIDTH bits on SCL falls, and aborts stalled frames.
module spi_target
    import spi_pkg::*;
#(
    parameter  int WRITE_WIDTH = 16,
    parameter  int READ_WIDTH  = 0,
    parameter  int TIMEOUT     = 64,
    localparam int RDW         = (READ_WIDTH > 0) ? READ_WIDTH : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   scl,
    input  logic                   sda_i,
    output logic                   sda_o,
    output logic                   sda_oe,
    output logic [WRITE_WIDTH-1:0] dout,
    output logic                   vout,
    input  logic [RDW-1:0]         rdata,
    output logic                   err,
    output logic                   busy,
    output spi_tgt_state_t         dbg_state
);

    localparam int BCW = $clog2(WRITE_WIDTH + 1);
    localparam int RCW = ctr_width(READ_WIDTH);
    localparam int ICW = $clog2(TIMEOUT + 1);

    logic w_scl_rise;
    logic w_scl_fall;
    logic w_unused_scl_level;
    logic w_sda;
    logic w_unused_sda_rise;
    logic w_unused_sda_fall;

    sync_edge u_scl_sync (
        .clk     (clk),
        .rst     (rst),
        .i_d     (scl),
        .o_level (w_unused_scl_level),
        .o_rise  (w_scl_rise),
        .o_fall  (w_scl_fall)
    );

    sync_edge u_sda_sync (
        .clk     (clk),
        .rst     (rst),
        .i_d     (sda_i),
        .o_level (w_sda),
        .o_rise  (w_unused_sda_rise),
        .o_fall  (w_unused_sda_fall)
    );

    spi_tgt_state_t         r_state;
    spi_tgt_state_t         w_state_nxt;
    logic [WRITE_WIDTH-2:0] r_sreg;
    logic [BCW-1:0]         r_bit_ctr;
    logic [RCW-1:0]         r_rd_ctr;
    logic [RDW-1:0]         r_rsh;
    logic [ICW-1:0]         r_idle_ctr;
    logic [WRITE_WIDTH-1:0] r_dout;
    logic                   r_vout;
    logic                   r_err;
    logic                   r_sda_o;
    logic                   r_sda_oe;

    logic w_edge;
    logic w_idle_hit;
    logic w_wr_shift;
    logic w_wr_done;
    logic w_rd_fall;
    logic w_rd_rise;
    logic w_rd_done;
    logic w_timeout;

    assign w_edge     = w_scl_rise | w_scl_fall;
    // Any edge clears the idle counter, so an edge always beats a timeout.
    assign w_idle_hit = (r_idle_ctr == ICW'(TIMEOUT - 1)) && !w_edge;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr_shift  = 1'b0;
        w_wr_done   = 1'b0;
        w_rd_fall   = 1'b0;
        w_rd_rise   = 1'b0;
        w_rd_done   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_scl_rise) begin
                    w_wr_shift  = 1'b1;
                    w_state_nxt = WR;
                end
            end
            WR: begin
                if (w_idle_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_scl_rise) begin
                    w_wr_shift = 1'b1;
                    if (r_bit_ctr == BCW'(WRITE_WIDTH - 1)) begin
                        w_wr_done   = 1'b1;
                        w_state_nxt = (READ_WIDTH == 0) ? IDLE : RD;
                    end
                end
            end
            RD: begin
                if (w_idle_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_rd_fall = w_scl_fall;
                    if (w_scl_rise) begin
                        w_rd_rise = 1'b1;
                        if (r_rd_ctr == RCW'(READ_WIDTH - 1)) begin
                            w_rd_done   = 1'b1;
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // vout is a valid-only strobe with no ready: dout changes only in the cycle vout is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sreg     <= '0;
            r_bit_ctr  <= '0;
            r_rd_ctr   <= '0;
            r_rsh      <= '0;
            r_idle_ctr <= '0;
            r_dout     <= '0;
            r_vout     <= 1'b0;
            r_err      <= 1'b0;
            r_sda_o    <= 1'b0;
            r_sda_oe   <= 1'b0;
        end else begin
            r_vout <= w_wr_done;
            r_err  <= w_timeout;

            if (r_state == IDLE || w_edge) begin
                r_idle_ctr <= '0;
            end else begin
                r_idle_ctr <= r_idle_ctr + 1'b1;
            end

            if (w_wr_shift) begin
                r_sreg    <= (WRITE_WIDTH - 1)'({r_sreg, w_sda});
                r_bit_ctr <= (r_state == IDLE) ? BCW'(1) : r_bit_ctr + 1'b1;
            end

            if (w_wr_done) begin
                r_dout <= {r_sreg, w_sda};
                if (READ_WIDTH > 0) begin
                    r_rsh    <= rdata;
                    r_rd_ctr <= '0;
                end
            end

            if (w_rd_fall) begin
                r_sda_oe <= 1'b1;
                r_sda_o  <= r_rsh[RDW-1];
                r_rsh    <= r_rsh << 1;
            end

            if (w_rd_rise) begin
                r_rd_ctr <= r_rd_ctr + 1'b1;
            end

            if (w_rd_done || w_timeout) begin
                r_sda_oe <= 1'b0;
            end
        end
    end

    assign sda_o     = r_sda_o;
    assign sda_oe    = r_sda_oe;
    assign dout      = r_dout;
    assign vout      = r_vout;
    assign err       = r_err;
    assign busy      = (r_state != IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: a write-only 16-bit instance and an 8/8 read-back instance,
// driven as a bit-banged initiator with a queue of expected received words.
module tb_spi_target;
    import spi_pkg::*;

    localparam int HALF = 10;
    localparam int TMO  = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic           scl16 = 1'b0;
    logic           sda16 = 1'b0;
    logic           sda_o16, sda_oe16, vout16, err16, busy16;
    logic [15:0]    dout16;
    logic [0:0]     rdata16 = 1'b0;
    spi_tgt_state_t st16;

    logic           scl8 = 1'b0;
    logic           sda8 = 1'b0;
    logic           sda_o8, sda_oe8, vout8, err8, busy8;
    logic [7:0]     dout8;
    logic [7:0]     rdata8 = 8'h00;
    spi_tgt_state_t st8;

    int n_cmp   = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_vout16 = 0;
    int n_err16  = 0;
    int n_err8   = 0;
    int vout16_cyc    = 0;
    int err16_cyc     = 0;
    int last_rise_cyc = 0;
    int fall_cyc      = 0;
    int err_before    = 0;
    int d;

    logic [15:0] exp16_q[$];
    logic [7:0]  exp8_q[$];

    spi_target #(.WRITE_WIDTH(16), .READ_WIDTH(0), .TIMEOUT(TMO)) u_dut16 (
        .clk(clk), .rst(rst), .scl(scl16), .sda_i(sda16), .sda_o(sda_o16),
        .sda_oe(sda_oe16), .dout(dout16), .vout(vout16), .rdata(rdata16),
        .err(err16), .busy(busy16), .dbg_state(st16)
    );

    spi_target #(.WRITE_WIDTH(8), .READ_WIDTH(8), .TIMEOUT(TMO)) u_dut8 (
        .clk(clk), .rst(rst), .scl(scl8), .sda_i(sda8), .sda_o(sda_o8),
        .sda_oe(sda_oe8), .dout(dout8), .vout(vout8), .rdata(rdata8),
        .err(err8), .busy(busy8), .dbg_state(st8)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // driver: initiator shifts MSB first, data changes while SCL is low
    task automatic xfer16(input logic [15:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            sda16 = w[15-i];
            tick(HALF);
            if (i == 1) check("busy16_mid", {31'd0, busy16}, 32'd1);
            scl16 = 1'b1;
            last_rise_cyc = cyc;
            tick(HALF);
            scl16 = 1'b0;
        end
        sda16 = 1'b0;
    endtask

    task automatic xfer8(input logic [7:0] w, input logic [7:0] rd_exp);
        for (int i = 0; i < 8; i++) begin
            sda8 = w[7-i];
            tick(HALF);
            check("sda_oe8_wr", {31'd0, sda_oe8}, 32'd0);
            scl8 = 1'b1;
            tick(HALF);
            scl8 = 1'b0;
        end
        sda8   = 1'b0;
        rdata8 = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            tick(HALF);
            check("sda_oe8_rd", {31'd0, sda_oe8}, 32'd1);
            check("sda_o8_bit", {31'd0, sda_o8}, {31'd0, rd_exp[7-i]});
            scl8 = 1'b1;
            tick(HALF);
            scl8 = 1'b0;
        end
        tick(HALF);
        check("sda_oe8_end", {31'd0, sda_oe8}, 32'd0);
    endtask

    // scoreboard: every vout pops one expected word
    always @(negedge clk) begin
        logic [15:0] e16;
        logic [7:0]  e8;
        if (vout16) begin
            n_vout16++;
            vout16_cyc = cyc;
            if (exp16_q.size() > 0) e16 = exp16_q.pop_front();
            else e16 = 16'hxxxx;
            check("dout16_word", {16'd0, dout16}, {16'd0, e16});
        end
        if (err16) begin
            n_err16++;
            err16_cyc = cyc;
        end
        if (vout8) begin
            if (exp8_q.size() > 0) e8 = exp8_q.pop_front();
            else e8 = 8'hxx;
            check("dout8_word", {24'd0, dout8}, {24'd0, e8});
        end
        if (err8) n_err8++;
    end

    initial begin
        rst = 1'b0;
        tick(4);
        check("rst_dout16",   {16'd0, dout16}, 32'd0);
        check("rst_vout16",   {31'd0, vout16}, 32'd0);
        check("rst_err16",    {31'd0, err16}, 32'd0);
        check("rst_busy16",   {31'd0, busy16}, 32'd0);
        check("rst_sda_oe16", {31'd0, sda_oe16}, 32'd0);
        check("rst_sda_o16",  {31'd0, sda_o16}, 32'd0);
        check("rst_state16",  {30'd0, st16}, {30'd0, IDLE});
        check("rst_dout8",    {24'd0, dout8}, 32'd0);
        check("rst_sda_oe8",  {31'd0, sda_oe8}, 32'd0);
        rst = 1'b1;
        tick(2);

        // single frame and vout latency
        exp16_q.push_back(16'hA5C3);
        xfer16(16'hA5C3, 16);
        tick(6);
        check("q16_drained_1", exp16_q.size(), 32'd0);
        check("dout16_a5c3", {16'd0, dout16}, 32'h0000_A5C3);
        check("vout16_latency", vout16_cyc - last_rise_cyc, 32'd3);
        check("busy16_after_1", {31'd0, busy16}, 32'd0);
        check("err16_none_1", n_err16, 32'd0);

        // back-to-back frames
        exp16_q.push_back(16'h0001);
        exp16_q.push_back(16'hFFFE);
        xfer16(16'h0001, 16);
        xfer16(16'hFFFE, 16);
        tick(6);
        check("q16_drained_2", exp16_q.size(), 32'd0);
        check("dout16_fffe", {16'd0, dout16}, 32'h0000_FFFE);
        check("vout16_count_2", n_vout16, 32'd3);

        // partial frame then silence
        err_before = n_err16;
        xfer16(16'h5500, 7);
        fall_cyc = cyc;
        tick(TMO + 10);
        check("err16_once", n_err16 - err_before, 32'd1);
        d = err16_cyc - fall_cyc;
        check("err16_delay_window", {31'd0, (d >= TMO && d <= TMO + 5)}, 32'd1);
        check("dout16_kept", {16'd0, dout16}, 32'h0000_FFFE);
        check("vout16_none_tmo", n_vout16, 32'd3);
        check("state16_idle_tmo", {30'd0, st16}, {30'd0, IDLE});
        exp16_q.push_back(16'h6D2B);
        xfer16(16'h6D2B, 16);
        tick(6);
        check("q16_drained_3", exp16_q.size(), 32'd0);
        check("dout16_6d2b", {16'd0, dout16}, 32'h0000_6D2B);

        // reset in the middle of a frame
        err_before = n_err16;
        xfer16(16'hBEEF, 9);
        rst = 1'b0;
        tick(1);
        check("mrst_dout16",   {16'd0, dout16}, 32'd0);
        check("mrst_busy16",   {31'd0, busy16}, 32'd0);
        check("mrst_vout16",   {31'd0, vout16}, 32'd0);
        check("mrst_err16",    {31'd0, err16}, 32'd0);
        check("mrst_sda_oe16", {31'd0, sda_oe16}, 32'd0);
        check("mrst_state16",  {30'd0, st16}, {30'd0, IDLE});
        rst = 1'b1;
        tick(TMO + 4);
        check("mrst_no_err", n_err16 - err_before, 32'd0);
        exp16_q.push_back(16'h1234);
        xfer16(16'h1234, 16);
        tick(6);
        check("q16_drained_4", exp16_q.size(), 32'd0);
        check("dout16_1234", {16'd0, dout16}, 32'h0000_1234);
        check("vout16_total", n_vout16, 32'd5);

        // write then read-back on the 8/8 instance
        rdata8 = 8'h3C;
        exp8_q.push_back(8'h81);
        xfer8(8'h81, 8'h3C);
        tick(6);
        check("q8_drained", exp8_q.size(), 32'd0);
        check("dout8_81", {24'd0, dout8}, 32'h0000_0081);
        check("busy8_after", {31'd0, busy8}, 32'd0);
        check("sda_oe8_idle", {31'd0, sda_oe8}, 32'd0);
        check("err8_none", n_err8, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
